// File: rtl/seg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_pkg : segment patterns, BCD codes and capture FSM states.  Rev 1.0
// ---------------------------------------------------------------------------
package seg_pkg;

  // Active-low g..a patterns as produced by the display encoder
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_BAD   = 4'hE;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seg_to_bcd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_to_bcd : decodes one active-low segment byte to BCD, dp and err.  Rev 1.0
// ---------------------------------------------------------------------------
module seg_to_bcd
  import seg_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] bcd,
  output logic       dp,
  output logic       err
);

  always_comb begin
    bcd = BCD_BAD;
    err = 1'b1;
    dp  = ~seg[7];
    case (seg[6:0])
      SEG_0:     begin bcd = 4'd0;      err = 1'b0; end
      SEG_1:     begin bcd = 4'd1;      err = 1'b0; end
      SEG_2:     begin bcd = 4'd2;      err = 1'b0; end
      SEG_3:     begin bcd = 4'd3;      err = 1'b0; end
      SEG_4:     begin bcd = 4'd4;      err = 1'b0; end
      SEG_5:     begin bcd = 4'd5;      err = 1'b0; end
      SEG_6:     begin bcd = 4'd6;      err = 1'b0; end
      SEG_7:     begin bcd = 4'd7;      err = 1'b0; end
      SEG_8:     begin bcd = 4'd8;      err = 1'b0; end
      SEG_9:     begin bcd = 4'd9;      err = 1'b0; end
      SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
      default:   begin bcd = BCD_BAD;   err = 1'b1; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_capture : debounces a multiplexed 7-seg bus into BCD frames.  Rev 1.0
// ---------------------------------------------------------------------------
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            segment,
  input  logic [DIGITS-1:0]     digit_sel,
  input  logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  overrun
);

  localparam int c_cnt_w = $clog2(STABLE_CYC + 1);
  localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);
  localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_sel;
  logic [7:0]          r_dwell_seg;
  logic [DIGITS-1:0]   r_dwell_sel;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_armed;

  state_t              r_state;
  logic [c_idx_w-1:0]  r_idx;
  logic [c_tmo_w-1:0]  r_tmo;
  logic [4*DIGITS-1:0] r_sh_bcd;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_sh_err;

  logic                w_changed;
  logic [3:0]          w_lows;
  logic [c_idx_w-1:0]  w_acc_idx;
  logic                w_accept;
  logic                w_last;
  logic                w_commit;
  logic [3:0]          w_dig_bcd;
  logic                w_dig_dp;
  logic                w_dig_err;
  logic [4*DIGITS-1:0] w_frm_bcd;
  logic [DIGITS-1:0]   w_frm_dp;
  logic [DIGITS-1:0]   w_frm_err;

  seg_to_bcd u_dec (
    .seg (r_dwell_seg),
    .bcd (w_dig_bcd),
    .dp  (w_dig_dp),
    .err (w_dig_err)
  );

  assign w_changed = (r_seg != r_dwell_seg) || (r_sel != r_dwell_sel);

  // Only an exactly-one-low select names a digit; blanking and overlaps never accept
  always_comb begin
    w_lows    = 4'd0;
    w_acc_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_dwell_sel[i]) begin
        w_lows    = w_lows + 4'd1;
        w_acc_idx = c_idx_w'(i);
      end
    end
  end

  assign w_accept = r_armed && (r_cnt == c_cnt_w'(STABLE_CYC)) && (w_lows == 4'd1);
  assign w_last   = (w_acc_idx == c_idx_w'(DIGITS - 1));
  assign w_commit = w_accept && w_last &&
                    ((r_state == COLLECT) ? (w_acc_idx == r_idx) : (w_acc_idx == '0));

  always_comb begin
    w_frm_bcd = r_sh_bcd;
    w_frm_dp  = r_sh_dp;
    w_frm_err = r_sh_err;
    w_frm_bcd[{w_acc_idx, 2'b00} +: 4] = w_dig_bcd;
    w_frm_dp[w_acc_idx]  = w_dig_dp;
    w_frm_err[w_acc_idx] = w_dig_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg       <= '1;
      r_sel       <= '1;
      r_dwell_seg <= '1;
      r_dwell_sel <= '1;
      r_cnt       <= '0;
      r_armed     <= 1'b1;
    end else begin
      r_seg       <= segment;
      r_sel       <= digit_sel;
      r_dwell_seg <= r_seg;
      r_dwell_sel <= r_sel;
      if (w_changed) begin
        r_cnt   <= c_cnt_w'(1);
        r_armed <= 1'b1;
      end else begin
        if (r_cnt != c_cnt_w'(STABLE_CYC)) r_cnt <= r_cnt + c_cnt_w'(1);
        if (w_accept) r_armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_tmo    <= '0;
      r_sh_bcd <= '0;
      r_sh_dp  <= '0;
      r_sh_err <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tmo <= '0;
          if (w_accept && (w_acc_idx == '0)) begin
            r_sh_bcd <= w_frm_bcd;
            r_sh_dp  <= w_frm_dp;
            r_sh_err <= w_frm_err;
            if (DIGITS > 1) begin
              r_state <= COLLECT;
              r_idx   <= c_idx_w'(1);
            end
          end
        end
        COLLECT: begin
          if (w_accept) begin
            r_tmo <= '0;
            if (w_acc_idx == r_idx) begin
              r_sh_bcd <= w_frm_bcd;
              r_sh_dp  <= w_frm_dp;
              r_sh_err <= w_frm_err;
              if (w_last) begin
                r_state <= IDLE;
                r_idx   <= '0;
              end else begin
                r_idx <= r_idx + c_idx_w'(1);
              end
            end else if (w_acc_idx == '0) begin
              r_sh_bcd <= w_frm_bcd;
              r_sh_dp  <= w_frm_dp;
              r_sh_err <= w_frm_err;
              r_idx    <= c_idx_w'(1);
            end else begin
              r_state <= IDLE;
              r_idx   <= '0;
            end
          end else if (r_tmo == c_tmo_w'(TIMEOUT_CYC)) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + c_tmo_w'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // A frame completing while the consumer stalls is dropped; the held one wins
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      bcd_out <= '0;
      dp_out  <= '0;
      err_out <= '0;
      overrun <= 1'b0;
    end else if (w_commit) begin
      if (valid && !ready) begin
        overrun <= 1'b1;
      end else begin
        valid   <= 1'b1;
        bcd_out <= w_frm_bcd;
        dp_out  <= w_frm_dp;
        err_out <= w_frm_err;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_scan_capture : scoreboard bench with a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_seg_scan_capture;

  localparam int DIGITS      = 4;
  localparam int STABLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 4096;

  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   err;
  } frame_t;

  logic                  clk       = 1'b0;
  logic                  rst       = 1'b1;
  logic [7:0]            segment   = 8'hFF;
  logic [DIGITS-1:0]     digit_sel = '1;
  logic                  ready     = 1'b1;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     dp_out;
  logic [DIGITS-1:0]     err_out;
  logic                  overrun;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  bit     rnd_ready = 1'b0;

  frame_t exp_q[$];
  frame_t part;
  frame_t mon_e;
  int     part_n     = 0;
  int     last_start = -100000;
  bit     model_ovr  = 1'b0;

  seg_scan_capture #(
    .DIGITS      (DIGITS),
    .STABLE_CYC  (STABLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .segment   (segment),
    .digit_sel (digit_sel),
    .ready     (ready),
    .valid     (valid),
    .bcd_out   (bcd_out),
    .dp_out    (dp_out),
    .err_out   (err_out),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] ref_bcd(input logic [7:0] s);
    logic [3:0] r;
    r = 4'hE;
    if (s[6:0] == 7'h7F) r = 4'hF;
    for (int v = 0; v < 10; v++) if (s[6:0] == PAT[v]) r = 4'(v);
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] sel_of(input int k);
    logic [DIGITS-1:0] s;
    s    = '1;
    s[k] = 1'b0;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: a dwell is a digit if one-hot and long enough; frames are 0..DIGITS-1 in order
  task automatic model_dwell(input logic [DIGITS-1:0] sel_n, input logic [7:0] seg, input int len);
    int lows;
    int idx;
    lows = 0;
    idx  = 0;
    for (int i = 0; i < DIGITS; i++) if (!sel_n[i]) begin lows++; idx = i; end
    if (lows != 1 || len < STABLE_CYC) return;
    if (part_n > 0 && (cyc - last_start) > TIMEOUT_CYC) part_n = 0;
    last_start = cyc;
    if (idx == 0) part_n = 0;
    if (idx == part_n) begin
      part.bcd[4*idx +: 4] = ref_bcd(seg);
      part.dp[idx]         = ~seg[7];
      part.err[idx]        = (ref_bcd(seg) == 4'hE);
      part_n++;
    end else begin
      part_n = 0;
    end
    if (part_n == DIGITS) begin
      part_n = 0;
      if (exp_q.size() > 0) model_ovr = 1'b1;
      else exp_q.push_back(part);
    end
  endtask

  task automatic model_reset();
    part_n = 0;
    exp_q.delete();
    model_ovr = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic dwell(input logic [DIGITS-1:0] sel_n, input logic [7:0] seg, input int len, input int gap);
    model_dwell(sel_n, seg, len);
    digit_sel = sel_n;
    segment   = seg;
    step(len);
    digit_sel = '1;
    segment   = 8'hFF;
    step(gap);
  endtask

  task automatic scan(input logic [8*DIGITS-1:0] segs, input int len);
    for (int k = 0; k < DIGITS; k++) dwell(sel_of(k), segs[8*k +: 8], len, 2);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},   valid,   0);
    check({tag, "_bcd"},     bcd_out, 0);
    check({tag, "_dp"},      dp_out,  0);
    check({tag, "_err"},     err_out, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected frame
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame: got bcd=%h dp=%b err=%b with none expected", bcd_out, dp_out, err_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (bcd_out !== mon_e.bcd || dp_out !== mon_e.dp || err_out !== mon_e.err) begin
          bad++;
          $display("FAIL frame: got bcd=%h dp=%b err=%b expected bcd=%h dp=%b err=%b",
                   bcd_out, dp_out, err_out, mon_e.bcd, mon_e.dp, mon_e.err);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]        seg;
    logic [DIGITS-1:0] sel;
    int                len;
    int                r;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    step(2);

    // Clean scan 0..3 with latency and single-pulse checks on the last digit
    dwell(sel_of(0), 8'hC0, 8, 2);
    dwell(sel_of(1), 8'hF9, 8, 2);
    dwell(sel_of(2), 8'hA4, 8, 2);
    model_dwell(sel_of(3), 8'hB0, 8);
    digit_sel = sel_of(3);
    segment   = 8'hB0;
    step(STABLE_CYC + 1);
    check("lat_early", valid, 0);
    step(1);
    check("lat_rise", valid, 1);
    check("lat_bcd", bcd_out, 16'h3210);
    step(1);
    check("pulse_drop", valid, 0);
    step(8 - STABLE_CYC - 3);
    digit_sel = '1;
    segment   = 8'hFF;
    step(2);

    // Decimal point and blank digit
    scan(32'hFF128080, 8);
    step(4);

    // Bad pattern with a short final dwell, then with a full dwell
    dwell(sel_of(0), 8'hC0, 8, 2);
    dwell(sel_of(1), 8'hAA, 8, 2);
    dwell(sel_of(2), 8'hA4, 8, 2);
    dwell(sel_of(3), 8'hB0, 3, 2);
    step(4);
    check("short_dwell_no_valid", valid, 0);
    scan(32'hB0A4AAC0, 8);
    step(4);

    // Out-of-order scan, then a frozen select that must time out
    dwell(sel_of(0), 8'hC0, 8, 2);
    dwell(sel_of(1), 8'hF9, 8, 2);
    dwell(sel_of(3), 8'hB0, 8, 2);
    step(4);
    check("order_no_valid", valid, 0);
    dwell(sel_of(0), 8'hC0, 8, 2);
    dwell(sel_of(1), 8'hF9, 5000, 2);
    dwell(sel_of(2), 8'hA4, 8, 2);
    dwell(sel_of(3), 8'hB0, 8, 2);
    step(4);
    check("timeout_no_valid", valid, 0);
    scan(32'h90F88299, 8);
    step(4);

    // Stalled consumer across two frames
    ready = 1'b0;
    scan(32'h99B0A4F9, 8);
    scan(32'h80F88292, 8);
    check("ovr_valid_held", valid, 1);
    check("ovr_bcd_held", bcd_out, 16'h4321);
    check("ovr_set", overrun, 1);
    ready = 1'b1;
    step(1);
    check("ovr_valid_drop", valid, 0);
    step(2);
    check("ovr_sticky", overrun, model_ovr);

    // Reset in the middle of a frame
    dwell(sel_of(0), 8'hC0, 8, 2);
    dwell(sel_of(1), 8'hF9, 8, 2);
    rst = 1'b1;
    step(1);
    model_reset();
    check_reset_state("midreset");
    rst = 1'b0;
    step(2);
    scan(32'h8292F899, 8);
    step(4);

    // Randomized scans with occasional disorder, short dwells, overlaps and bad patterns
    rnd_ready = 1'b1;
    repeat (40) begin
      for (int k = 0; k < DIGITS; k++) begin
        sel = sel_of(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DIGITS - 1)) : k);
        if ($urandom_range(0, 19) == 0) sel[$urandom_range(0, DIGITS - 1)] = 1'b0;
        len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, STABLE_CYC - 1))
                                           : int'($urandom_range(STABLE_CYC, STABLE_CYC + 6));
        r = int'($urandom_range(0, 9));
        seg[7] = 1'($urandom_range(0, 1));
        if (r < 7)       seg[6:0] = PAT[$urandom_range(0, 9)];
        else if (r < 8)  seg[6:0] = 7'h7F;
        else             seg      = 8'($urandom);
        dwell(sel, seg, len, int'($urandom_range(1, 3)));
      end
    end
    rnd_ready = 1'b0;
    ready     = 1'b1;
    step(20);
    check("queue_drained", exp_q.size(), 0);
    check("overrun_final", overrun, model_ovr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
